seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider for the ALU datapath, extending the bitwise logic units with an iterative arithmetic unit. Accepts an N-bit dividend and divisor on a single-cycle start pulse, runs one quotient bit per clock, and returns the quotient, the remainder and a divide-by-zero flag. The control FSM sequences it through a start/busy/done handshake.

---
 rtl/seq_divider.sv | 108 ++++++++++
 tb/tb_seq_divider.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// Takes one quotient bit per clock and reports the quotient, the remainder
// and a divide-by-zero flag using a start/busy/done handshake.
module seq_divider #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [N:0]    r_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  d_reg;
    logic [CW-1:0] cnt;
    logic          dz_pend;

    logic [N:0]    r_sh;
    logic [N-1:0]  q_sh;
    logic [N+1:0]  t;
    logic [N:0]    r_new;
    logic [N-1:0]  q_new;
    logic          last_iter;

    // One restoring step: shift {R,Q} left, trial-subtract D, keep or restore
    always_comb begin
        r_sh  = {r_reg[N-1:0], q_reg[N-1]};
        q_sh  = {q_reg[N-2:0], 1'b0};
        t     = {1'b0, r_sh} - {2'b00, d_reg};
        r_new = r_sh;
        q_new = q_sh;
        if (!t[N+1]) begin
            r_new = t[N:0];
            q_new = q_sh | {{(N-1){1'b0}}, 1'b1};
        end
        last_iter = (cnt == CW'(N - 1));
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Control FSM, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            cnt         <= '0;
            dz_pend     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        q_reg   <= dividend;
                        d_reg   <= divisor;
                        r_reg   <= '0;
                        cnt     <= '0;
                        dz_pend <= (divisor == '0);
                        state   <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // A zero divisor spends exactly one busy cycle here so that
                    // done appears one edge after acceptance, with no iterations.
                    if (dz_pend) begin
                        quotient    <= '1;
                        remainder   <= q_reg;
                        div_by_zero <= 1'b1;
                        dz_pend     <= 1'b0;
                        state       <= S_DONE;
                    end else begin
                        r_reg <= r_new;
                        q_reg <= q_new;
                        cnt   <= cnt + CW'(1);
                        if (last_iter) begin
                            quotient    <= q_new;
                            remainder   <= r_new[N-1:0];
                            div_by_zero <= 1'b0;
                            state       <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random self-checking bench for seq_divider (N=8).
module tb_seq_divider;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int checks;
    int errors;

    seq_divider #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and wait (bounded) for done; lat counts edges after acceptance
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] q, output logic [N-1:0] r,
                          output logic dz, output int lat);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        q = quotient; r = remainder; dz = div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
        checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_E0: busy=%b done=%b expected busy=1 done=0", busy, done); end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== (k == 8) || busy !== (k < 8)) begin
                errors++; $display("FAIL basic_E%0d: busy=%b done=%b expected busy=%b done=%b", k, busy, done, (k < 8), (k == 8));
            end
            if (k == 8) begin
                checks++;
                if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
                    errors++; $display("FAIL basic_result: got %0d r %0d dbz %b expected 28 r 4 dbz 0", quotient, remainder, div_by_zero);
                end
            end
        end
    endtask

    task automatic test_edges();
        logic [N-1:0] a_t[3] = '{8'd5, 8'd255, 8'd255};
        logic [N-1:0] b_t[3] = '{8'd9, 8'd1, 8'd255};
        logic [N-1:0] q_t[3] = '{8'd0, 8'd255, 8'd1};
        logic [N-1:0] r_t[3] = '{8'd5, 8'd0, 8'd0};
        logic [N-1:0] q, r;
        logic dz;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(a_t[i], b_t[i], q, r, dz, lat);
            checks++;
            if (lat !== 8 || q !== q_t[i] || r !== r_t[i] || dz !== 1'b0) begin
                errors++; $display("FAIL edge_%0d_%0d: got %0d r %0d dbz %b lat %0d expected %0d r %0d dbz 0 lat 8",
                                   a_t[i], b_t[i], q, r, dz, lat, q_t[i], r_t[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [N-1:0] q, r;
        logic dz;
        int lat;
        run_op(8'd77, 8'd0, q, r, dz, lat);
        checks++;
        if (lat !== 1 || q !== 8'd255 || r !== 8'd77 || dz !== 1'b1) begin
            errors++; $display("FAIL div_zero: got %0d r %0d dbz %b lat %0d expected 255 r 77 dbz 1 lat 1", q, r, dz, lat);
        end
        run_op(8'd10, 8'd3, q, r, dz, lat);
        checks++;
        if (lat !== 8 || q !== 8'd3 || r !== 8'd1 || dz !== 1'b0) begin
            errors++; $display("FAIL after_zero: got %0d r %0d dbz %b lat %0d expected 3 r 1 dbz 0 lat 8", q, r, dz, lat);
        end
    endtask

    task automatic test_busy_protect();
        int dones;
        dones = 0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                checks++;
                if (k != 8 || quotient !== 8'd11 || remainder !== 8'd1) begin
                    errors++; $display("FAIL busy_result: edge %0d got %0d r %0d expected edge 8 11 r 1", k, quotient, remainder);
                end
            end
            if (k == 2) begin
                start = 1'b1; dividend = 8'd50; divisor = 8'd5;
            end else if (k == 3) begin
                start = 1'b0; dividend = 8'd123; divisor = 8'd45;
            end else if (k == 5) begin
                dividend = 8'd7; divisor = 8'd2;
            end
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", dones); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] q, r;
        logic dz;
        int lat;
        int dones;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (quotient !== 8'd0 || remainder !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL reset_mid_outputs: q=%0d r=%0d busy=%b done=%b dbz=%b expected all 0",
                               quotient, remainder, busy, done, div_by_zero);
        end
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (k == 2) rst_n = 1'b1;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", dones); end
        run_op(8'd13, 8'd4, q, r, dz, lat);
        checks++;
        if (lat !== 8 || q !== 8'd3 || r !== 8'd1 || dz !== 1'b0) begin
            errors++; $display("FAIL reset_mid_fresh: got %0d r %0d dbz %b lat %0d expected 3 r 1 dbz 0 lat 8", q, r, dz, lat);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || quotient !== 8'd28 || remainder !== 8'd4) begin
            errors++; $display("FAIL b2b_first: done=%b got %0d r %0d expected done=1 28 r 4", done, quotient, remainder);
        end
        start = 1'b1; dividend = 8'd9; divisor = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: done=%b busy=%b expected done=0 busy=1", done, busy);
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== (k == 8)) begin
                errors++; $display("FAIL b2b_done_E%0d: got %b expected %b", k, done, (k == 8));
            end
        end
        checks++;
        if (quotient !== 8'd4 || remainder !== 8'd1 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got %0d r %0d dbz %b expected 4 r 1 dbz 0", quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b, q, r;
        logic dz;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_op(a, b, q, r, dz, lat);
            checks++;
            if (lat !== 8 || q !== a / b || r !== a % b || dz !== 1'b0) begin
                errors++; $display("FAIL rand_%0d/%0d: got %0d r %0d dbz %b lat %0d expected %0d r %0d dbz 0 lat 8",
                                   a, b, q, r, dz, lat, a / b, a % b);
            end
            checks++;
            if (int'(q) * int'(b) + int'(r) != int'(a) || r >= b) begin
                errors++; $display("FAIL rand_invariant_%0d/%0d: got q=%0d r=%0d", a, b, q, r);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_edges();
        test_div_zero();
        test_busy_protect();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
